// File: rtl/scmp_mem_arbiter_pkg.sv
// Shared types, default widths and the arbitration rule for the SC/MP RAM arbiter.
package scmp_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int MEM_AW_DEF = 7;

    typedef enum logic [1:0] {IDLE, ACC, CAP} arb_state_t;
    typedef enum logic {GNT_CPU, GNT_DBG} grant_t;

    // Round-robin: on contention the side that did not win last time goes first.
    function automatic grant_t pick_grant(input logic cpu_cand, input logic dbg_cand,
                                          input grant_t last);
        if (cpu_cand && dbg_cand)
            return (last == GNT_DBG) ? GNT_CPU : GNT_DBG;
        return cpu_cand ? GNT_CPU : GNT_DBG;
    endfunction

endpackage

// File: rtl/scmp_mem_arbiter_if.sv
// Debug/loader request port of the RAM arbiter.
// Handshake: requester raises req with we/addr/wdata stable and holds it until ack; ack is a
// one-cycle pulse with rdata valid in that cycle. req seen in the ack cycle is ignored; req high
// in the following cycle is a new access.
interface scmp_mem_arbiter_if
    import scmp_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/scmp_mem_arbiter_strobe_sync.sv
// Multi-flop synchroniser for an active-low CPU strobe with a falling-edge pulse output.
// Flops reset to 1 (strobe inactive) so reset release never produces a spurious edge.
module strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic level,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], strobe_n};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign fall  = prev_q & ~sync_q[STAGES-1];
endmodule

// File: rtl/scmp_mem_arbiter.sv
// Shares one synchronous byte RAM between the SC/MP CPU strobe bus and a debug requester.
// Every access is two cycles (ACC drives the RAM, CAP collects read data) after an IDLE grant.
module scmp_mem_arbiter
    import scmp_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_AW      = MEM_AW_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_rd_n,
    input  logic                  cpu_wr_n,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_ready,
    scmp_mem_arbiter_if.slave     dbg,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output arb_state_t            arb_state
);
    logic rd_level, rd_fall, wr_level, wr_fall;

    strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
        .clk(clk), .rst_n(rst_n), .strobe_n(cpu_rd_n), .level(rd_level), .fall(rd_fall)
    );
    strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
        .clk(clk), .rst_n(rst_n), .strobe_n(cpu_wr_n), .level(wr_level), .fall(wr_fall)
    );

    arb_state_t        state, state_nxt;
    grant_t            last_grant, grant_nxt, gnt;
    logic              cur_we, we_nxt;
    logic              cpu_pend, cpu_op_wr, cpu_done;
    logic [MEM_AW-1:0] addr_nxt;
    logic              mem_we_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              dbg_ack_q, ack_nxt;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_nxt;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_nxt;
    logic              cpu_fall, cpu_cand, cpu_wr_now, dbg_cand;
    logic              unused_hi;

    // A fresh edge is granted in the cycle it is seen; it is also latched so it survives a busy FSM.
    // Both strobes low counts as a write because the synced write level is checked at the edge.
    assign cpu_fall   = rd_fall | wr_fall;
    assign cpu_cand   = cpu_pend | cpu_fall;
    assign cpu_wr_now = cpu_fall ? ~wr_level : cpu_op_wr;
    assign dbg_cand   = dbg.req & ~dbg_ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_pend  <= 1'b0;
            cpu_op_wr <= 1'b0;
        end else begin
            if (cpu_done)
                cpu_pend <= 1'b0;
            if (cpu_fall) begin
                cpu_pend  <= 1'b1;
                cpu_op_wr <= ~wr_level;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= GNT_DBG;
            cur_we      <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state       <= state_nxt;
            last_grant  <= grant_nxt;
            cur_we      <= we_nxt;
            mem_addr    <= addr_nxt;
            mem_we      <= mem_we_nxt;
            mem_wdata   <= wdata_nxt;
            dbg_ack_q   <= ack_nxt;
            dbg_rdata_q <= dbg_rdata_nxt;
            cpu_rdata_q <= cpu_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = last_grant;
        we_nxt        = cur_we;
        addr_nxt      = mem_addr;
        mem_we_nxt    = 1'b0;
        wdata_nxt     = mem_wdata;
        ack_nxt       = 1'b0;
        dbg_rdata_nxt = dbg_rdata_q;
        cpu_rdata_nxt = cpu_rdata_q;
        cpu_done      = 1'b0;
        gnt           = pick_grant(cpu_cand, dbg_cand, last_grant);
        unique case (state)
            IDLE: begin
                if (cpu_cand || dbg_cand) begin
                    state_nxt = ACC;
                    grant_nxt = gnt;
                    if (gnt == GNT_CPU) begin
                        addr_nxt = cpu_addr[MEM_AW-1:0];
                        we_nxt   = cpu_wr_now;
                        if (cpu_wr_now)
                            wdata_nxt = cpu_wdata;
                    end else begin
                        addr_nxt = dbg.addr[MEM_AW-1:0];
                        we_nxt   = dbg.we;
                        if (dbg.we)
                            wdata_nxt = dbg.wdata;
                    end
                    mem_we_nxt = we_nxt;
                end
            end
            ACC: state_nxt = CAP;
            CAP: begin
                state_nxt = IDLE;
                if (last_grant == GNT_DBG) begin
                    ack_nxt = 1'b1;
                    if (!cur_we)
                        dbg_rdata_nxt = mem_rdata;
                end else begin
                    cpu_done = 1'b1;
                    if (!cur_we)
                        cpu_rdata_nxt = mem_rdata;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Upper address bits alias onto the small RAM.
    assign unused_hi = ^{cpu_addr[ADDR_W-1:MEM_AW], dbg.addr[ADDR_W-1:MEM_AW]};

    assign cpu_rdata = cpu_rd_n ? '1 : cpu_rdata_q;
    assign cpu_ready = ~(cpu_pend | cpu_fall);
    assign dbg.ack   = dbg_ack_q;
    assign dbg.rdata = dbg_rdata_q;
    assign arb_state = state;
endmodule

// File: tb/tb_scmp_mem_arbiter.sv
// Bench for scmp_mem_arbiter: sync RAM model, request tasks, reference memory and a scoreboard.
module tb_scmp_mem_arbiter;
    import scmp_mem_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int MEM_AW = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_rd_n, cpu_wr_n;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_ready;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    arb_state_t        arb_state;

    scmp_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg_bus ();

    scmp_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg(dbg_bus.slave),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .arb_state(arb_state)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- RAM (128x8, 1-cycle read) ----------------
    logic [7:0] ram [128];
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // ---------------- reference model + scoreboard ----------------
    logic [7:0]  ref_mem [128];
    logic [8:0]  exp_cpu_q[$];
    logic [8:0]  exp_dbg_q[$];
    logic [14:0] exp_wr_q[$];
    grant_t      model_last;
    int          compared   = 0;
    int          mismatched = 0;
    int          we_cnt     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a RAM write, a debug ack or a CPU completion.
    initial begin
        logic [14:0] ew;
        logic [8:0]  ed;
        logic        ready_prev;
        ready_prev = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (mem_we) begin
                    we_cnt++;
                    chk("wr_expected", exp_wr_q.size() > 0, 1);
                    if (exp_wr_q.size() > 0) begin
                        ew = exp_wr_q.pop_front();
                        chk("wr_addr", mem_addr, ew[14:8]);
                        chk("wr_data", mem_wdata, ew[7:0]);
                    end
                end
                if (dbg_bus.ack) begin
                    chk("dbg_ack_expected", exp_dbg_q.size() > 0, 1);
                    if (exp_dbg_q.size() > 0) begin
                        ed = exp_dbg_q.pop_front();
                        if (ed[8]) chk("dbg_rdata", dbg_bus.rdata, ed[7:0]);
                    end
                end
                if (cpu_ready && !ready_prev) begin
                    chk("cpu_done_expected", exp_cpu_q.size() > 0, 1);
                    if (exp_cpu_q.size() > 0) begin
                        ed = exp_cpu_q.pop_front();
                        if (ed[8]) chk("cpu_rdata", cpu_rdata, ed[7:0]);
                    end
                end
            end
            ready_prev = cpu_ready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_access(input bit wr, input logic [11:0] addr, input logic [7:0] wd,
                              input bit push_wr, input int exp_lat);
        int n;
        bit busy, done;
        @(negedge clk);
        cpu_addr  = addr;
        cpu_wdata = wd;
        if (wr) begin
            ref_mem[addr[6:0]] = wd;
            if (push_wr) exp_wr_q.push_back({addr[6:0], wd});
            exp_cpu_q.push_back({1'b0, 8'h00});
            cpu_wr_n = 1'b0;
        end else begin
            exp_cpu_q.push_back({1'b1, ref_mem[addr[6:0]]});
            cpu_rd_n = 1'b0;
        end
        n = 0; busy = 0; done = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!cpu_ready) busy = 1;
            else if (busy) done = 1;
        end
        chk("cpu_done", done, 1);
        if (done) model_last = GNT_CPU;
        if (exp_lat != 0) chk("cpu_latency", n, exp_lat);
        @(negedge clk);
        cpu_rd_n = 1'b1;
        cpu_wr_n = 1'b1;
        #1;
        if (!wr) chk("cpu_rdata_idle", cpu_rdata, 8'hFF);
        repeat (3) @(negedge clk);
    endtask

    task automatic dbg_access(input bit we, input logic [11:0] addr, input logic [7:0] wd,
                              input bit push_wr, input int exp_lat);
        int n;
        bit done;
        @(negedge clk);
        dbg_bus.we    = we;
        dbg_bus.addr  = addr;
        dbg_bus.wdata = wd;
        dbg_bus.req   = 1'b1;
        if (we) begin
            ref_mem[addr[6:0]] = wd;
            if (push_wr) exp_wr_q.push_back({addr[6:0], wd});
            exp_dbg_q.push_back({1'b0, 8'h00});
        end else begin
            exp_dbg_q.push_back({1'b1, ref_mem[addr[6:0]]});
        end
        n = 0; done = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (dbg_bus.ack) done = 1;
        end
        chk("dbg_done", done, 1);
        if (done) model_last = GNT_DBG;
        if (exp_lat != 0) chk("dbg_latency", n, exp_lat);
        @(negedge clk);
        dbg_bus.req = 1'b0;
    endtask

    // Both sides write in the same IDLE cycle; the expected RAM write order follows round-robin.
    task automatic contention(input logic [11:0] ca, input logic [7:0] cd,
                              input logic [11:0] da, input logic [7:0] dd);
        if (model_last == GNT_DBG) begin
            exp_wr_q.push_back({ca[6:0], cd});
            exp_wr_q.push_back({da[6:0], dd});
        end else begin
            exp_wr_q.push_back({da[6:0], dd});
            exp_wr_q.push_back({ca[6:0], cd});
        end
        fork
            cpu_access(1'b1, ca, cd, 1'b0, 0);
            begin
                repeat (2) @(negedge clk);
                dbg_access(1'b1, da, dd, 1'b0, 0);
            end
        join
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int w0;
        bit hit;
        logic [7:0] v;
        rst_n = 1'b0;
        cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        dbg_bus.req = 1'b0; dbg_bus.we = 1'b0; dbg_bus.addr = '0; dbg_bus.wdata = '0;
        model_last = GNT_DBG;
        for (int i = 0; i < 128; i++) begin
            v = 8'($urandom_range(0, 255));
            if (i == 5) v = 8'hA5;
            ram[i] <= v;
            ref_mem[i] = v;
        end
        repeat (3) @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_dbg_ack", dbg_bus.ack, 0);
        chk("rst_dbg_rdata", dbg_bus.rdata, 0);
        chk("rst_cpu_ready", cpu_ready, 1);
        chk("rst_cpu_rdata_idle", cpu_rdata, 8'hFF);
        chk("rst_state", arb_state, IDLE);
        cpu_rd_n = 1'b0;
        #1 chk("rst_cpu_rdata_reg", cpu_rdata, 0);
        cpu_rd_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CPU read of aliased address 0x085 -> RAM 0x05, data after the 5th edge
        fork
            cpu_access(1'b0, 12'h085, 8'h00, 1'b1, 5);
            begin
                @(negedge clk);
                repeat (3) @(posedge clk);
                #1;
                chk("cpu_rd_mem_addr", mem_addr, 7'h05);
                chk("cpu_rd_state_acc", arb_state, ACC);
            end
        join

        // CPU write to 0x17F: one write pulse at 0x7F
        w0 = we_cnt;
        cpu_access(1'b1, 12'h17F, 8'h3C, 1'b1, 5);
        chk("cpu_wr_pulses", we_cnt - w0, 1);
        chk("ram_7f", ram[7'h7F], 8'h3C);

        // Debug write then read back
        dbg_access(1'b1, 12'h010, 8'h5A, 1'b1, 3);
        dbg_access(1'b0, 12'h010, 8'h00, 1'b1, 3);
        chk("dbg_rdata_5a", dbg_bus.rdata, 8'h5A);

        // Contention: last grant DBG -> CPU first; then after a lone CPU access -> DBG first
        contention(12'h140, 8'h11, 12'h041, 8'h22);
        chk("dbg_rdata_held", dbg_bus.rdata, 8'h5A);
        cpu_access(1'b0, 12'h041, 8'h00, 1'b1, 5);
        contention(12'h042, 8'h33, 12'h043, 8'h44);
        dbg_access(1'b0, 12'h042, 8'h00, 1'b1, 3);

        // CPU edge while a debug access is in ACC: CPU served right after it
        fork
            cpu_access(1'b0, 12'h010, 8'h00, 1'b1, 7);
            begin
                @(negedge clk);
                dbg_access(1'b1, 12'h033, 8'h77, 1'b1, 3);
            end
        join

        // Reset in the middle of a debug write
        @(negedge clk);
        v = ~ref_mem[7'h22];
        dbg_bus.we = 1'b1; dbg_bus.addr = 12'h022; dbg_bus.wdata = v; dbg_bus.req = 1'b1;
        exp_wr_q.push_back({7'h22, v});
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (mem_we) hit = 1;
        end
        chk("rst_mid_saw_we", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_we", mem_we, 0);
        chk("rst_mid_cpu_ready", cpu_ready, 1);
        chk("rst_mid_state", arb_state, IDLE);
        dbg_bus.req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_no_ack", dbg_bus.ack, 0);
        rst_n = 1'b1;
        model_last = GNT_DBG;
        repeat (4) @(negedge clk);
        dbg_access(1'b0, 12'h022, 8'h00, 1'b1, 3);
        cpu_access(1'b1, 12'h0A2, 8'h9E, 1'b1, 5);
        cpu_access(1'b0, 12'h022, 8'h00, 1'b1, 5);

        // Randomized single-requester traffic
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1)
                cpu_access(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                           8'($urandom_range(0, 255)), 1'b1, 5);
            else
                dbg_access(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                           8'($urandom_range(0, 255)), 1'b1, 3);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        chk("drain_cpu_q", exp_cpu_q.size(), 0);
        chk("drain_dbg_q", exp_dbg_q.size(), 0);
        chk("drain_wr_q", exp_wr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
